// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
//
// Multi-channel ring-oscillator frequency counter. One of CHANNELS ring
// outputs (already pre-divided outside this block) is enabled and left to
// settle. Its rising edges are then counted over a gate window of gate_len
// system clocks. The saturating result is presented in parallel on o_count.
// It can also be read MSB-first, one bit per i_shift_en pulse, on
// o_shift_out.
//
// Parameters
//   CHANNELS : number of ring-oscillator inputs (>= 2)
//   COUNT_W  : edge-counter width
//   GATE_W   : gate-length width
//   SETTLE   : clk cycles the selected ring runs before the gate opens (>= 3)
//   SEL_W    : width of the channel selector (derived)
//
// Ports
//   i_clk       system clock, all state changes on its rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     measurement request, sampled every cycle
//   i_chan_sel  channel to measure, latched on an accepted start
//   i_gate_len  gate window length in clk cycles, latched on an accepted start
//   i_ro_in     ring outputs, asynchronous to i_clk
//   o_ro_ena    ring enables, one-hot while measuring, otherwise all zero
//   o_busy      high while arming or gating
//   o_done      high once a result is available
//   o_overflow  sticky: the counter saturated during this measurement
//   o_count     measured edge count / shift register contents
//   i_shift_en  in DONE, shifts o_count left by one bit
//   o_shift_out always o_count[COUNT_W-1]
// ---------------------------------------------------------------------------
module ro_freq_counter #(
   parameter int CHANNELS = 4,
   parameter int COUNT_W  = 16,
   parameter int GATE_W   = 16,
   parameter int SETTLE   = 8,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [SEL_W-1:0]    i_chan_sel,
   input  logic [GATE_W-1:0]   i_gate_len,
   input  logic [CHANNELS-1:0] i_ro_in,
   output logic [CHANNELS-1:0] o_ro_ena,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_overflow,
   output logic [COUNT_W-1:0]  o_count,
   input  logic                i_shift_en,
   output logic                o_shift_out
);

   // The settle counter only has to reach SETTLE-1.
   localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

   // One extra bit so that CHANNELS itself is representable (e.g. 4 on 2 bits).
   localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t              r_state;
   logic [SEL_W-1:0]    r_sel;
   logic [GATE_W-1:0]   r_gate_len;
   logic [SET_W-1:0]    r_settle;
   logic [GATE_W-1:0]   r_gate_cnt;
   logic                r_sync1;
   logic                r_sync2;
   logic                r_prev;
   logic [COUNT_W-1:0]  r_count;
   logic                r_overflow;
   logic                r_busy;
   logic                r_done;
   logic [CHANNELS-1:0] r_ro_ena;

   // ------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------
   state_t              w_state_next;
   logic [SEL_W-1:0]    w_sel_next;
   logic [GATE_W-1:0]   w_gate_len_next;
   logic [SET_W-1:0]    w_settle_next;
   logic [GATE_W-1:0]   w_gate_cnt_next;
   logic [COUNT_W-1:0]  w_count_next;
   logic                w_overflow_next;
   logic                w_busy_next;
   logic                w_done_next;
   logic [CHANNELS-1:0] w_sel_onehot;
   logic                w_sel_ok;
   logic                w_accept;
   logic                w_pulse;

   assign w_sel_ok = ({1'b0, i_chan_sel} < CH_LIMIT);
   assign w_accept = i_start && w_sel_ok &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // Rising edge of the synchronised ring signal. It is only used in GATE.
   // In ARM the same registers are simply being primed.
   assign w_pulse = r_sync2 & ~r_prev;

   // The one-hot enable is decoded from the selector that will be in force
   // after this edge. A newly accepted channel is therefore enabled on the
   // accept edge itself.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ena
      assign w_sel_onehot[gi] = (w_sel_next == SEL_W'(gi));
   end

   // ------------------------------------------------------------------
   // FSM next-state / datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_sel_next      = r_sel;
      w_gate_len_next = r_gate_len;
      w_settle_next   = r_settle;
      w_gate_cnt_next = r_gate_cnt;
      w_count_next    = r_count;
      w_overflow_next = r_overflow;

      case (r_state)
         ST_IDLE: begin
            // Waits for an accepted start; see override below.
         end

         ST_ARM: begin
            if (r_settle == SETTLE_LAST) begin
               if (r_gate_len == '0) begin
                  // Empty window: the result is the cleared count.
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next    = ST_GATE;
                  w_gate_cnt_next = r_gate_len;
               end
            end else begin
               w_settle_next = r_settle + SET_W'(1);
            end
         end

         ST_GATE: begin
            if (w_pulse) begin
               if (&r_count) begin
                  // An edge arrived with no room left: hold and flag it.
                  w_overflow_next = 1'b1;
               end else begin
                  w_count_next = r_count + COUNT_W'(1);
               end
            end
            w_gate_cnt_next = r_gate_cnt - GATE_W'(1);
            // The cycle that takes the counter to zero is the last one
            // counted, so exactly gate_len cycles are observed.
            if (r_gate_cnt == GATE_W'(1)) begin
               w_state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            if (i_shift_en) begin
               w_count_next = {r_count[COUNT_W-2:0], 1'b0};
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // An accepted start overrides everything, including a shift in DONE.
      if (w_accept) begin
         w_state_next    = ST_ARM;
         w_sel_next      = i_chan_sel;
         w_gate_len_next = i_gate_len;
         w_settle_next   = '0;
         w_count_next    = '0;
         w_overflow_next = 1'b0;
      end

      w_busy_next = (w_state_next == ST_ARM) || (w_state_next == ST_GATE);
      w_done_next = (w_state_next == ST_DONE);
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sel      <= '0;
         r_gate_len <= '0;
         r_settle   <= '0;
         r_gate_cnt <= '0;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_prev     <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ro_ena   <= '0;
      end else begin
         r_sel      <= w_sel_next;
         r_gate_len <= w_gate_len_next;
         r_settle   <= w_settle_next;
         r_gate_cnt <= w_gate_cnt_next;
         // The synchroniser runs all the time on the latched channel. After
         // a channel change the SETTLE (>= 3) ARM cycles flush the old
         // channel out of sync1, sync2 and prev before the gate opens.
         r_sync1    <= i_ro_in[r_sel];
         r_sync2    <= r_sync1;
         r_prev     <= r_sync2;
         r_count    <= w_count_next;
         r_overflow <= w_overflow_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_ro_ena   <= w_busy_next ? w_sel_onehot : '0;
      end
   end

   assign o_ro_ena    = r_ro_ena;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_overflow  = r_overflow;
   assign o_count     = r_count;
   assign o_shift_out = r_count[COUNT_W-1];

endmodule

// File: tb/tb_ro_freq_counter.sv
module tb_ro_freq_counter;

   localparam int CH   = 4;
   localparam int CW   = 16;
   localparam int GW   = 16;
   localparam int ST   = 8;
   localparam int SW   = 2;
   localparam int B_CH = 3;
   localparam int B_CW = 4;
   localparam int B_GW = 8;
   localparam int B_ST = 3;
   localparam int B_SW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters
   logic          start    = 1'b0;
   logic [SW-1:0] chan_sel = '0;
   logic [GW-1:0] gate_len = '0;
   logic [CH-1:0] ro_in    = '0;
   logic          shift_en = 1'b0;
   logic [CH-1:0] ro_ena;
   logic          busy, done, overflow, shift_out;
   logic [CW-1:0] count;

   // Instance B: 3 channels, 4-bit counter
   logic            b_start    = 1'b0;
   logic [B_SW-1:0] b_chan_sel = '0;
   logic [B_GW-1:0] b_gate_len = '0;
   logic            b_shift_en = 1'b0;
   logic [B_CH-1:0] b_ro_ena;
   logic            b_busy, b_done, b_overflow, b_shift_out;
   logic [B_CW-1:0] b_count;

   ro_freq_counter #(.CHANNELS(CH), .COUNT_W(CW), .GATE_W(GW), .SETTLE(ST)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_chan_sel(chan_sel),
      .i_gate_len(gate_len), .i_ro_in(ro_in), .o_ro_ena(ro_ena), .o_busy(busy),
      .o_done(done), .o_overflow(overflow), .o_count(count),
      .i_shift_en(shift_en), .o_shift_out(shift_out));

   ro_freq_counter #(.CHANNELS(B_CH), .COUNT_W(B_CW), .GATE_W(B_GW), .SETTLE(B_ST)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_chan_sel(b_chan_sel),
      .i_gate_len(b_gate_len), .i_ro_in(ro_in[B_CH-1:0]), .o_ro_ena(b_ro_ena),
      .o_busy(b_busy), .o_done(b_done), .o_overflow(b_overflow), .o_count(b_count),
      .i_shift_en(b_shift_en), .o_shift_out(b_shift_out));

   // Ring waveform per channel: hp>0 square wave of half period hp,
   // hp==0 static at lvl, hp<0 random bit every cycle.
   int   hp  [CH];
   logic lvl [CH];

   // Record the ring inputs as seen at every rising clk edge.
   int            cyc = 0;
   logic [CH-1:0] hist [0:32767];
   always @(posedge clk) begin
      hist[cyc] <= ro_in;
      cyc       <= cyc + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge, then drive the rings for the next cycle.
   task automatic step();
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
         if (hp[c] == 0)     ro_in[c] = lvl[c];
         else if (hp[c] < 0) ro_in[c] = 1'($urandom_range(0, 1));
         else                ro_in[c] = ((cyc / hp[c]) % 2) == 1;
      end
   endtask

   // Reference: the gate observes gate_len cycles starting SETTLE edges after
   // the accept edge t0, and sees the ring 2 cycles late. A counted edge is a
   // rising transition between consecutive clk samples; the result saturates.
   task automatic model(input int t0, input int sel, input int glen, input int settle,
                        input int cmax, output int cnt, output bit ovf);
      int edges = 0;
      for (int k = t0 + settle + 1; k <= t0 + settle + glen; k++) begin
         if (hist[k-2][sel] && !hist[k-3][sel]) edges++;
      end
      ovf = (edges > cmax);
      cnt = ovf ? cmax : edges;
   endtask

   // One measurement on instance A. poke >= 0 issues an extra start (which
   // must be ignored) that many cycles after the accept edge.
   task automatic run_meas(input string tag, input int sel, input int glen, input int poke,
                           input bit shen, input bit use_exp, input int exp_cnt, input bit exp_ovf);
      int            t0;
      int            waited;
      int            m_cnt;
      bit            m_ovf;
      logic [CH-1:0] onehot;
      chan_sel = SW'(sel);
      gate_len = GW'(glen);
      start    = 1'b1;
      shift_en = shen;
      step();
      start  = 1'b0;
      t0     = cyc - 1;
      onehot = CH'(1) << sel;
      check({tag, " busy"}, 32'(busy), 1);
      check({tag, " ro_ena"}, 32'(ro_ena), 32'(onehot));
      check({tag, " cleared"}, 32'({overflow, count}), 0);
      waited = 0;
      while (!done && waited < ST + glen + 20) begin
         if (waited == poke) begin
            start    = 1'b1;
            chan_sel = SW'((sel + 1) % CH);
            gate_len = GW'(3);
         end
         step();
         start = 1'b0;
         waited++;
      end
      shift_en = 1'b0;
      check({tag, " done"}, 32'(done), 1);
      if (!done) return;
      check({tag, " latency"}, 32'(cyc - 1 - t0), 32'(ST + glen));
      if (use_exp) begin
         m_cnt = exp_cnt;
         m_ovf = exp_ovf;
      end else begin
         model(t0, sel, glen, ST, (1 << CW) - 1, m_cnt, m_ovf);
      end
      check({tag, " count"}, 32'(count), 32'(m_cnt));
      check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, " idle outs"}, 32'({busy, ro_ena}), 0);
      $display("meas %s: sel=%0d gate=%0d count=%0d ovf=%0d", tag, sel, glen, count, overflow);
   endtask

   typedef struct {
      int         sel;
      int         glen;
      int         h0, h1, h2, h3;
      logic [3:0] lv;
      int         exp_cnt;
      bit         exp_ovf;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            t0;
      int            w;
      int            m_cnt;
      bit            m_ovf;
      int            r;
      logic [15:0]   pat;

      for (int c = 0; c < CH; c++) begin
         hp[c]  = 0;
         lvl[c] = 1'b0;
      end

      // sel, glen, half periods ch0..ch3, static levels, expected count/ovf
      tbl[0] = '{2, 64,  0, 0, 4, 0, 4'b0000, 8,  1'b0};  // basic P=8
      tbl[1] = '{0, 40,  2, 0, 0, 0, 4'b0000, 10, 1'b0};  // fastest exact P=4
      tbl[2] = '{1, 60,  0, 3, 0, 0, 4'b0000, 10, 1'b0};  // P=6
      tbl[3] = '{3, 100, 0, 0, 0, 5, 4'b0000, 10, 1'b0};  // P=10
      tbl[4] = '{1, 80,  2, 0, 2, 2, 4'b0010, 0,  1'b0};  // isolation, sel high
      tbl[5] = '{2, 80,  2, 2, 0, 2, 4'b0000, 0,  1'b0};  // isolation, sel low
      tbl[6] = '{0, 0,   2, 0, 0, 0, 4'b0000, 0,  1'b0};  // empty window
      tbl[7] = '{2, 4,   0, 0, 2, 0, 4'b0000, 1,  1'b0};  // one period

      // Reset state
      step();
      step();
      check("reset A outs", 32'({busy, done, overflow, shift_out, ro_ena}), 0);
      check("reset A count", 32'(count), 0);
      check("reset B outs", 32'({b_busy, b_done, b_overflow, b_ro_ena, b_count}), 0);
      rst_n = 1'b1;
      step();

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         hp[0] = tbl[i].h0;
         hp[1] = tbl[i].h1;
         hp[2] = tbl[i].h2;
         hp[3] = tbl[i].h3;
         for (int c = 0; c < CH; c++) lvl[c] = tbl[i].lv[c];
         run_meas($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].glen, -1, 1'b0, 1'b1,
                  tbl[i].exp_cnt, tbl[i].exp_ovf);
      end

      // Start during GATE is ignored
      hp[0] = 0; hp[1] = 4; hp[2] = 0; hp[3] = 0;
      run_meas("gate_poke", 1, 48, ST + 10, 1'b0, 1'b1, 6, 1'b0);

      // Shift-out of 0x00A5 (165 edges at P=4 over 660 cycles)
      hp[0] = 2; hp[1] = 0;
      run_meas("shift_load", 0, 660, -1, 1'b0, 1'b1, 165, 1'b0);
      pat = 16'h00A5;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("shift bit %0d", i), 32'(shift_out), 32'(pat[15-i]));
         shift_en = 1'b1;
         step();
      end
      shift_en = 1'b0;
      check("shift final count", 32'(count), 0);
      check("shift still done", 32'(done), 1);

      // Randomised measurements against the reference
      for (int i = 0; i < 30; i++) begin
         int sel;
         int glen;
         int poke;
         for (int c = 0; c < CH; c++) begin
            r      = $urandom_range(0, 7);
            hp[c]  = (r <= 1) ? 0 : (r == 7) ? -1 : r;
            lvl[c] = 1'($urandom_range(0, 1));
         end
         sel  = $urandom_range(0, CH - 1);
         glen = $urandom_range(0, 80);
         poke = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ST + glen - 1) : -1;
         run_meas($sformatf("rnd%0d", i), sel, glen, poke, 1'($urandom_range(0, 1)),
                  1'b0, 0, 1'b0);
      end

      // Asynchronous reset mid-GATE
      for (int c = 0; c < CH; c++) hp[c] = 0;
      hp[0]    = 2;
      chan_sel = '0;
      gate_len = GW'(200);
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (ST + 50) step();
      check("pre-reset busy", 32'(busy), 1);
      check("pre-reset count nonzero", 32'(count != 0), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outs", 32'({busy, done, overflow, shift_out, ro_ena}), 0);
      check("async reset count", 32'(count), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post-reset idle", 32'({busy, done, ro_ena, count}), 0);
      run_meas("after_reset", 0, 40, -1, 1'b0, 1'b1, 10, 1'b0);

      // Instance B: out-of-range channel is ignored
      b_chan_sel = 2'd3;
      b_gate_len = 8'd10;
      b_start    = 1'b1;
      step();
      b_start = 1'b0;
      check("B bad sel ignored", 32'({b_busy, b_done, b_ro_ena}), 0);
      step();
      step();
      check("B bad sel still idle", 32'({b_busy, b_done, b_ro_ena}), 0);

      // Instance B: saturation of the 4-bit counter (25 edges)
      hp[0] = 0; hp[1] = 2; hp[2] = 0;
      b_chan_sel = 2'd1;
      b_gate_len = 8'd100;
      b_start    = 1'b1;
      step();
      b_start = 1'b0;
      t0      = cyc - 1;
      check("B sat ro_ena", 32'({b_busy, b_ro_ena}), 32'(4'b1010));
      w = 0;
      while (!b_done && w < 200) begin
         step();
         w++;
      end
      check("B sat done", 32'(b_done), 1);
      check("B sat latency", 32'(cyc - 1 - t0), 32'(B_ST + 100));
      check("B sat count", 32'(b_count), 15);
      check("B sat overflow", 32'(b_overflow), 1);
      model(t0, 1, 100, B_ST, 15, m_cnt, m_ovf);
      check("B sat model count", 32'(b_count), 32'(m_cnt));
      $display("meas B_sat: count=%0d ovf=%0d", b_count, b_overflow);

      // Bad channel while in DONE: nothing changes
      b_chan_sel = 2'd3;
      b_start    = 1'b1;
      step();
      b_start = 1'b0;
      check("B bad sel in DONE", 32'({b_done, b_overflow, b_count, b_shift_out}), 32'(7'b1111111));

      // Restart clears count and overflow
      hp[0]      = 0;
      lvl[0]     = 1'b0;
      b_chan_sel = 2'd0;
      b_gate_len = 8'd10;
      b_start    = 1'b1;
      step();
      b_start = 1'b0;
      check("B restart clears", 32'({b_busy, b_done, b_overflow, b_count}), 32'(7'b1000000));
      w = 0;
      while (!b_done && w < 50) begin
         step();
         w++;
      end
      check("B restart done", 32'(b_done), 1);
      check("B restart result", 32'({b_overflow, b_count}), 0);
      $display("meas B_restart: count=%0d ovf=%0d", b_count, b_overflow);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
